seg7_frame_writer: RTL and testbench
====================================

Name: seg7_frame_writer

Overview:
- Producer side of the 4-digit 7-segment display write port (en_w / waddr / data).
- On a start request it captures a 16-bit value, dot mask and blanking flag, encodes each nibble to active-low segment bytes, and issues four sequential single-cycle writes.
- Sits between application logic (counters, debug values) and the display controller, so callers never handle segment codes.

Parameters:
- GAP_CYCLES, 0, idle cycles inserted between consecutive writes (0..255).
- HEX_EN, 1, 1: nibbles A-F shown as A,b,C,d,E,F; 0: nibbles >9 shown as '-' (segment g only).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  update request, sampled each posedge.
- value  in  16  digit 3 = value[15:12] ... digit 0 = value[3:0].
- dots  in  4  dots[i]=1 lights the dot of digit i.
- blank_lz  in  1  1: blank leading zeros (digit 0 never blanked).
- en_w  out  1  write strobe to display port, registered.
- waddr  out  2  digit address, registered.
- data  out  8  bit7 = dot, bits6:0 = g..a; all active-low; registered.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse after frame completes.

Behaviour:
- Reset (async, rst=0): en_w=0, waddr=0, data=8'hFF, busy=0, done=0, pending cleared, FSM=IDLE. Reset mid-frame abandons the frame; no further writes.
- FSM: IDLE -> WRITE -> (GAP if GAP_CYCLES>0) -> WRITE ... -> DONE -> IDLE.
- IDLE: start=1 captures value/dots/blank_lz into a frame register; next cycle enters WRITE with digit index 3.
- WRITE: en_w=1 for exactly one cycle with waddr=index, data=enc(index); index decrements 3,2,1,0. After index 0 go to DONE; otherwise go to GAP, or directly to the next WRITE if GAP_CYCLES=0.
- GAP: en_w=0 for GAP_CYCLES cycles, with waddr/data held.
- DONE: done=1 and busy=0 for one cycle, en_w=0. start is accepted in DONE exactly as in IDLE.
- busy=1 in WRITE and GAP only.
- Latency with GAP_CYCLES=0: start at cycle 0 gives writes at cycles 1-4 (addr 3,2,1,0) and done at cycle 5. In general, writes occur at cycles 1 + k*(GAP_CYCLES+1), k=0..3, and done follows one cycle after the last write.
- Start while busy=1:
  - Set pending; overwrite a pending capture register with the current value/dots/blank_lz (latest wins, single entry).
  - The current frame is unaffected.
  - In the DONE cycle, pending is cleared, the capture is transferred to the frame register, and the next frame's first write occurs on the following cycle.
  - start asserted in that same DONE cycle overrides the pending capture.
- Encoding, active-low, dot off: 0:C0 1:F9 2:A4 3:B0 4:99 5:92 6:82 7:F8 8:80 9:90 A:88 b:83 C:C6 d:A1 E:86 F:8E; '-' = BF.
- Dot: dots[i]=1 clears bit7.
- Blanking: digit i (i=3..1) is blanked when blank_lz=1, its nibble is 0, and every higher nibble is 0. A blanked digit has bits6:0 = 7F; its dot still follows dots[i].
- start held high continuously: a new frame starts after every DONE.

Test Plan:
- GAP=0, value=16'h1234, dots=0, blank_lz=0, start pulse -> cycles 1-4: (3,F9),(2,A4),(1,B0),(0,99); done=1 cycle 5; busy=1 cycles 1-4 only.
- blank_lz=1, value=16'h0005 -> FF,FF,FF,92; value=16'h0000, dots=4'b0001 -> FF,FF,FF,40; value=16'h0100 -> FF,F9,C0,C0.
- HEX_EN=0, value=16'hA0F9 -> BF,C0,BF,90; HEX_EN=1 same value -> 88,C0,8E,90.
- GAP_CYCLES=2, value=16'h8888 -> en_w at cycles 1,4,7,10 only; done at cycle 11.
- start with 16'h1111 at cycle 0; start with 16'h2222 at cycle 2, then 16'h3333 at cycle 3 -> frame 1111 completes, done cycle 5, frame 3333 writes cycles 6-9; 2222 never written.
- Drop rst at cycle 2 of a frame -> en_w=0, data=FF, busy=0 immediately; no writes after rst releases until a new start.

Source files
------------

// File: rtl/seg7_frame_writer.sv
// Encodes a 16-bit value to active-low 7-segment bytes and writes digits 3..0 to the display port.
// Latency: first write 1 cycle after start, then one write every GAP_CYCLES+1 cycles, done 1 cycle after the last; no backpressure, a start while busy is held as one pending frame (latest wins).
module seg7_frame_writer #(
    parameter int GAP_CYCLES = 0,
    parameter bit HEX_EN     = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] value,
    input  logic [3:0]  dots,
    input  logic        blank_lz,
    output logic        en_w,
    output logic [1:0]  waddr,
    output logic [7:0]  data,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, WRITE, GAP, DONE} state_t;

    typedef struct packed {
        logic [15:0] value;
        logic [3:0]  dots;
        logic        blank_lz;
    } frame_t;

    state_t     state, state_nxt;
    logic [1:0] idx, idx_nxt;
    logic [7:0] gap_cnt, gap_nxt;
    frame_t     frame, frame_nxt;
    frame_t     cap, cap_nxt;
    logic       pend, pend_nxt;
    frame_t     req;

    assign req = '{value: value, dots: dots, blank_lz: blank_lz};

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        if (!HEX_EN && n > 4'h9) s = 7'h3F;
        return s;
    endfunction

    // A digit is blank when it and every digit above it are zero.
    function automatic logic [7:0] enc(input frame_t f, input logic [1:0] i);
        logic [15:0] upper;
        logic        blanked;
        upper   = f.value >> {i, 2'b00};
        blanked = f.blank_lz && (i != 2'd0) && (upper == 16'h0000);
        return {~f.dots[i], blanked ? 7'h7F : seg_of(upper[3:0])};
    endfunction

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        gap_nxt   = gap_cnt;
        frame_nxt = frame;
        cap_nxt   = cap;
        pend_nxt  = pend;
        case (state)
            IDLE, DONE: begin
                pend_nxt  = 1'b0;
                state_nxt = IDLE;
                if (start) begin
                    frame_nxt = req;
                    idx_nxt   = 2'd3;
                    state_nxt = WRITE;
                end else if (state == DONE && pend) begin
                    frame_nxt = cap;
                    idx_nxt   = 2'd3;
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                if (idx == 2'd0) begin
                    state_nxt = DONE;
                end else if (GAP_CYCLES == 0) begin
                    idx_nxt = idx - 2'd1;
                end else begin
                    gap_nxt   = 8'(GAP_CYCLES - 1);
                    state_nxt = GAP;
                end
            end
            default: begin
                if (gap_cnt == 8'd0) begin
                    idx_nxt   = idx - 2'd1;
                    state_nxt = WRITE;
                end else begin
                    gap_nxt = gap_cnt - 8'd1;
                end
            end
        endcase
        if ((state == WRITE || state == GAP) && start) begin
            pend_nxt = 1'b1;
            cap_nxt  = req;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            idx     <= 2'd0;
            gap_cnt <= 8'd0;
            frame   <= '0;
            cap     <= '0;
            pend    <= 1'b0;
            en_w    <= 1'b0;
            waddr   <= 2'd0;
            data    <= 8'hFF;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            idx     <= idx_nxt;
            gap_cnt <= gap_nxt;
            frame   <= frame_nxt;
            cap     <= cap_nxt;
            pend    <= pend_nxt;
            en_w    <= (state_nxt == WRITE);
            busy    <= (state_nxt == WRITE) || (state_nxt == GAP);
            done    <= (state_nxt == DONE);
            if (state_nxt == WRITE) begin
                waddr <= idx_nxt;
                data  <= enc(frame_nxt, idx_nxt);
            end
        end
    end

endmodule

// File: tb/tb_seg7_frame_writer.sv
// Directed bench for seg7_frame_writer: three instances (default, HEX_EN=0, GAP_CYCLES=2) share stimulus.
module tb_seg7_frame_writer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [15:0] value = 16'h0000;
    logic [3:0]  dots = 4'h0;
    logic        blank_lz = 1'b0;

    logic       en_w, busy, done, en_w_nh, busy_nh, done_nh, en_w_gp, busy_gp, done_gp;
    logic [1:0] waddr, waddr_nh, waddr_gp;
    logic [7:0] data, data_nh, data_gp;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    seg7_frame_writer dut (
        .clk(clk), .rst(rst), .start(start), .value(value), .dots(dots), .blank_lz(blank_lz),
        .en_w(en_w), .waddr(waddr), .data(data), .busy(busy), .done(done)
    );

    seg7_frame_writer #(.GAP_CYCLES(0), .HEX_EN(1'b0)) dut_nh (
        .clk(clk), .rst(rst), .start(start), .value(value), .dots(dots), .blank_lz(blank_lz),
        .en_w(en_w_nh), .waddr(waddr_nh), .data(data_nh), .busy(busy_nh), .done(done_nh)
    );

    seg7_frame_writer #(.GAP_CYCLES(2), .HEX_EN(1'b1)) dut_gp (
        .clk(clk), .rst(rst), .start(start), .value(value), .dots(dots), .blank_lz(blank_lz),
        .en_w(en_w_gp), .waddr(waddr_gp), .data(data_gp), .busy(busy_gp), .done(done_gp)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Wait (bounded) until every instance is back in IDLE.
    task automatic settle();
        int k;
        k = 0;
        while (k < 60 && (busy || done || busy_nh || done_nh || busy_gp || done_gp)) begin
            @(negedge clk);
            k++;
        end
        check("settle", 16'(k < 60), 16'h1);
        @(negedge clk);
    endtask

    // exp / exp_nh pack the expected bytes for digits {3,2,1,0}.
    task automatic run_frame(input logic [15:0] v, input logic [3:0] d, input logic b,
                             input logic [31:0] exp, input logic [31:0] exp_nh);
        int di;
        @(negedge clk);
        value = v; dots = d; blank_lz = b; start = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c <= 4) begin
                di = 4 - c;
                check($sformatf("%h en_w c%0d", v, c), 16'(en_w), 16'h1);
                check($sformatf("%h waddr c%0d", v, c), 16'(waddr), 16'(di));
                check($sformatf("%h data c%0d", v, c), 16'(data), 16'(exp[8*di +: 8]));
                check($sformatf("%h data_nh c%0d", v, c), 16'(data_nh), 16'(exp_nh[8*di +: 8]));
                check($sformatf("%h busy c%0d", v, c), 16'(busy), 16'h1);
                check($sformatf("%h done c%0d", v, c), 16'(done), 16'h0);
            end else begin
                check($sformatf("%h en_w c5", v), 16'(en_w), 16'h0);
                check($sformatf("%h busy c5", v), 16'(busy), 16'h0);
                check($sformatf("%h done c5", v), 16'(done), 16'h1);
            end
        end
        settle();
    endtask

    initial begin
        int writes;
        int dones;
        repeat (2) @(negedge clk);
        check("rst en_w", 16'(en_w), 16'h0);
        check("rst waddr", 16'(waddr), 16'h0);
        check("rst data", 16'(data), 16'h00FF);
        check("rst busy", 16'(busy), 16'h0);
        check("rst done", 16'(done), 16'h0);
        rst = 1'b1;
        @(negedge clk);

        run_frame(16'h1234, 4'b0000, 1'b0, 32'hF9A4B099, 32'hF9A4B099);
        run_frame(16'h0005, 4'b0000, 1'b1, 32'hFFFFFF92, 32'hFFFFFF92);
        run_frame(16'h0000, 4'b0001, 1'b1, 32'hFFFFFF40, 32'hFFFFFF40);
        run_frame(16'h0100, 4'b0000, 1'b1, 32'hFFF9C0C0, 32'hFFF9C0C0);
        run_frame(16'hA0F9, 4'b0000, 1'b0, 32'h88C08E90, 32'hBFC0BF90);
        run_frame(16'hBCDE, 4'b1010, 1'b0, 32'h03C62186, 32'h3FBF3FBF);
        run_frame(16'h0007, 4'b1000, 1'b1, 32'h7FFFFFF8, 32'h7FFFFFF8);

        // GAP_CYCLES=2 instance: writes at 1,4,7,10, done at 11.
        @(negedge clk);
        value = 16'h8888; dots = 4'h0; blank_lz = 1'b0; start = 1'b1;
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            start = 1'b0;
            check($sformatf("gap en_w c%0d", c), 16'(en_w_gp), 16'(c == 1 || c == 4 || c == 7 || c == 10));
            check($sformatf("gap done c%0d", c), 16'(done_gp), 16'(c == 11));
            check($sformatf("gap busy c%0d", c), 16'(busy_gp), 16'(c <= 10));
            if (c == 1 || c == 4 || c == 7 || c == 10) begin
                check($sformatf("gap data c%0d", c), 16'(data_gp), 16'h0080);
                check($sformatf("gap waddr c%0d", c), 16'(waddr_gp), 16'(3 - (c - 1) / 3));
            end
        end
        settle();

        // Pending: 1111 at c0, 2222 at c2, 3333 at c3 -> 1111 then 3333.
        @(negedge clk);
        value = 16'h1111; dots = 4'h0; blank_lz = 1'b0; start = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            check($sformatf("pend en_w c%0d", c), 16'(en_w), 16'(c != 5 && c != 10));
            check($sformatf("pend done c%0d", c), 16'(done), 16'(c == 5 || c == 10));
            if (c <= 4) begin
                check($sformatf("pend waddr c%0d", c), 16'(waddr), 16'(4 - c));
                check($sformatf("pend data c%0d", c), 16'(data), 16'h00F9);
            end else if (c >= 6 && c <= 9) begin
                check($sformatf("pend waddr c%0d", c), 16'(waddr), 16'(9 - c));
                check($sformatf("pend data c%0d", c), 16'(data), 16'h00B0);
            end
            start = (c == 2 || c == 3);
            value = (c == 2) ? 16'h2222 : 16'h3333;
        end
        start = 1'b0;
        settle();

        // start held high: back-to-back frames after every done.
        @(negedge clk);
        value = 16'h1234; start = 1'b1;
        writes = 0;
        dones = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            writes += int'(en_w);
            dones += int'(done);
        end
        start = 1'b0;
        check("held writes", 16'(writes), 16'd8);
        check("held dones", 16'(dones), 16'd2);
        settle();

        // Reset mid-frame.
        @(negedge clk);
        value = 16'h1234; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst en_w", 16'(en_w), 16'h0);
        check("midrst data", 16'(data), 16'h00FF);
        check("midrst busy", 16'(busy), 16'h0);
        check("midrst busy_gp", 16'(busy_gp), 16'h0);
        @(negedge clk);
        rst = 1'b1;
        writes = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            writes += int'(en_w) + int'(en_w_nh) + int'(en_w_gp) + int'(done);
        end
        check("postrst activity", 16'(writes), 16'd0);

        run_frame(16'h1234, 4'b0000, 1'b0, 32'hF9A4B099, 32'hF9A4B099);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
